// File: rtl/ff_bank_multimode.sv
// WIDTH-channel flip-flop bank with a shared SR/JK/D/T mode, per-channel enables, forbidden-SR
// detection and a saturating error counter. Build option: SR_SET_DOMINANT_EN (SR=11 sets q).
module ff_bank_multimode #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     en,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic [WIDTH-1:0]     illegal,
  output logic                 err_any,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
    if (val == CNT_MAX) return val;
    return val + ERR_CNT_W'(1);
  endfunction

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ill_nxt;

  assign mode_sel = mode_t'(mode);
  assign qbar     = ~q;

  always_comb begin
    q_nxt   = q;
    ill_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case (mode_sel)
          MODE_SR: begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11: begin
                ill_nxt[i] = 1'b1;
`ifdef SR_SET_DOMINANT_EN
                q_nxt[i] = 1'b1;
`endif
              end
              default: q_nxt[i] = q[i];
            endcase
          end
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   q_nxt[i] = ~q[i];
              default: q_nxt[i] = q[i];
            endcase
          end
          MODE_D:  q_nxt[i] = a[i];
          MODE_T:  q_nxt[i] = q[i] ^ a[i];
          default: q_nxt[i] = q[i];
        endcase
      end
    end
  end

  // Stage boundary: state, flags and counter; err_cnt counts the already-registered err_any.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      illegal <= '0;
      err_any <= 1'b0;
      err_cnt <= '0;
    end else begin
      q       <= q_nxt;
      illegal <= ill_nxt;
      err_any <= |ill_nxt;
      if (err_any) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Scoreboard bench for ff_bank_multimode (WIDTH=8, ERR_CNT_W=3); honours SR_SET_DOMINANT_EN.
module tb_ff_bank_multimode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0, b = '0, en = '0;
  logic [7:0] q, qbar, illegal;
  logic       err_any;
  logic [2:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] ill;
    logic       ea;
    logic [2:0] cnt;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] m_q   = '0;
  logic [7:0] m_ill = '0;
  logic       m_ea  = 1'b0;
  logic [2:0] m_cnt = '0;

  ff_bank_multimode #(.WIDTH(8), .ERR_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .a(a), .b(b), .en(en),
    .q(q), .qbar(qbar), .illegal(illegal), .err_any(err_any), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drive one edge, advance the bit-parallel reference model, queue its expectation.
  task automatic drive(input logic r, input logic [1:0] md, input logic [7:0] aa, bb, ee);
    logic [7:0] sel;
    exp_t e;
    rst = r; mode = md; a = aa; b = bb; en = ee;
    @(posedge clk);
    if (r) begin
      m_q = '0; m_ill = '0; m_ea = 1'b0; m_cnt = '0;
    end else begin
      if (m_ea && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
      case (md)
`ifdef SR_SET_DOMINANT_EN
        2'b00: sel = aa | (m_q & ~bb);
`else
        2'b00: sel = (aa & ~bb) | (m_q & ~(aa ^ bb));
`endif
        2'b01: sel = (aa & ~m_q) | (~bb & m_q);
        2'b10: sel = aa;
        default: sel = m_q ^ aa;
      endcase
      m_ill = (md == 2'b00) ? (ee & aa & bb) : 8'h00;
      m_ea  = |m_ill;
      m_q   = (ee & sel) | (~ee & m_q);
    end
    e.q = m_q; e.ill = m_ill; e.ea = m_ea; e.cnt = m_cnt;
    sbq.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF);
      e = sbq.pop_front();
      checks++;
      if ({q, qbar, illegal, err_any, err_cnt} !== {e.q, ~e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL reset_sb got q=%h qbar=%h ill=%h ea=%b cnt=%0d exp q=%h ill=%h cnt=%0d",
                 q, qbar, illegal, err_any, err_cnt, e.q, e.ill, e.cnt);
      end
    end
    checks++;
    if ({q, qbar, illegal, err_cnt} !== {8'h00, 8'hFF, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_const got q=%h qbar=%h ill=%h cnt=%0d exp q=00 qbar=ff ill=00 cnt=0",
               q, qbar, illegal, err_cnt);
    end
  endtask

  task automatic test_sr();
    logic [7:0] sa[3] = '{8'hFF, 8'h00, 8'h00};
    logic [7:0] sb[3] = '{8'h00, 8'h0F, 8'h00};
    logic [7:0] sq[3] = '{8'hFF, 8'hF0, 8'hF0};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, sa[k], sb[k], 8'hFF);
      e = sbq.pop_front();
      checks++;
      if ({q, qbar, illegal, err_any, err_cnt} !== {e.q, ~e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL sr_sb step %0d got q=%h qbar=%h ill=%h exp q=%h ill=%h", k, q, qbar,
                 illegal, e.q, e.ill);
      end
      checks++;
      if (q !== sq[k] || qbar !== ~sq[k]) begin
        errors++;
        $display("FAIL sr_const step %0d got q=%h qbar=%h exp q=%h", k, q, qbar, sq[k]);
      end
    end
  endtask

  task automatic test_forbidden();
    exp_t e;
    logic [7:0] want_q;
`ifdef SR_SET_DOMINANT_EN
    want_q = 8'hF1;
`else
    want_q = 8'hF0;
`endif
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b0, 2'b00, 8'h81, 8'h81, 8'hFF);
      else       drive(1'b0, 2'b00, 8'h00, 8'h00, 8'hFF);
      e = sbq.pop_front();
      checks++;
      if ({q, qbar, illegal, err_any, err_cnt} !== {e.q, ~e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL forbid_sb step %0d got q=%h ill=%h ea=%b cnt=%0d exp q=%h ill=%h ea=%b cnt=%0d",
                 k, q, illegal, err_any, err_cnt, e.q, e.ill, e.ea, e.cnt);
      end
      if (k < 3) begin
        checks++;
        if (q !== want_q || illegal !== 8'h81 || err_any !== 1'b1) begin
          errors++;
          $display("FAIL forbid_const step %0d got q=%h ill=%h ea=%b exp q=%h ill=81 ea=1",
                   k, q, illegal, err_any, want_q);
        end
      end
    end
    checks++;
    if (err_cnt !== 3'd3 || illegal !== 8'h00) begin
      errors++;
      $display("FAIL forbid_cnt got cnt=%0d ill=%h exp cnt=3 ill=00", err_cnt, illegal);
    end
  endtask

  task automatic test_jk_t();
    logic [7:0] sq[4] = '{8'h0F, 8'h00, 8'h0F, 8'h0C};
    exp_t e;
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    void'(sbq.pop_front());
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b0, 2'b01, 8'hFF, 8'hFF, 8'h0F);
      else       drive(1'b0, 2'b11, 8'h33, 8'h00, 8'h0F);
      e = sbq.pop_front();
      checks++;
      if ({q, qbar, illegal, err_any, err_cnt} !== {e.q, ~e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL jkt_sb step %0d got q=%h ill=%h exp q=%h ill=%h", k, q, illegal, e.q, e.ill);
      end
      checks++;
      if (q !== sq[k] || illegal !== 8'h00) begin
        errors++;
        $display("FAIL jkt_const step %0d got q=%h ill=%h exp q=%h ill=00", k, q, illegal, sq[k]);
      end
    end
  endtask

  task automatic test_d_reset();
    exp_t e;
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    void'(sbq.pop_front());
    drive(1'b0, 2'b10, 8'hA5, 8'hFF, 8'hFF);
    e = sbq.pop_front();
    checks++;
    if (q !== e.q || q !== 8'hA5 || illegal !== 8'h00) begin
      errors++;
      $display("FAIL d_load got q=%h ill=%h exp q=%h ill=00", q, illegal, e.q);
    end
    drive(1'b1, 2'b10, 8'h5A, 8'h00, 8'hFF);
    e = sbq.pop_front();
    checks++;
    if ({q, qbar, err_cnt} !== {8'h00, 8'hFF, 3'd0} || q !== e.q) begin
      errors++;
      $display("FAIL d_midreset got q=%h qbar=%h cnt=%0d exp q=00 qbar=ff cnt=0", q, qbar, err_cnt);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) drive(1'b0, 2'b00, 8'h01, 8'h01, 8'h01);
      else        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h01);
      e = sbq.pop_front();
      checks++;
      if ({q, illegal, err_any, err_cnt} !== {e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL sat_sb step %0d got cnt=%0d ea=%b exp cnt=%0d ea=%b",
                 k, err_cnt, err_any, e.cnt, e.ea);
      end
    end
    checks++;
    if (err_cnt !== 3'd7) begin
      errors++;
      $display("FAIL sat_hold got cnt=%0d exp 7", err_cnt);
    end
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00);
    void'(sbq.pop_front());
    checks++;
    if (err_cnt !== 3'd0 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got cnt=%0d ea=%b exp cnt=0 ea=0", err_cnt, err_any);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 60; k++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
      e = sbq.pop_front();
      checks++;
      if ({q, qbar, illegal, err_any, err_cnt} !== {e.q, ~e.q, e.ill, e.ea, e.cnt}) begin
        errors++;
        $display("FAIL b2b step %0d mode=%b got q=%h ill=%h ea=%b cnt=%0d exp q=%h ill=%h ea=%b cnt=%0d",
                 k, mode, q, illegal, err_any, err_cnt, e.q, e.ill, e.ea, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sr();
    test_forbidden();
    test_jk_t();
    test_d_reset();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
